// File: rtl/lfsr_gen.sv
// Galois LFSR sequence generator with seed load, zero-seed protection and wrap detection.
// Define LFSR_PERIOD_EN to add the measured-period outputs PERIOD / PERIOD_VALID.
module lfsr_gen #(
  parameter int unsigned           WIDTH = 16,
  parameter logic [WIDTH-1:0]      TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0]      SEED  = 16'hACE1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] SEED_IN,
  output logic [WIDTH-1:0] Q,
  output logic             WRAP,
`ifdef LFSR_PERIOD_EN
  output logic             ZERO_ERR,
  output logic [WIDTH-1:0] PERIOD,
  output logic             PERIOD_VALID
`else
  output logic             ZERO_ERR
`endif
);

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "lfsr_gen: WIDTH must be in 3..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $fatal(1, "lfsr_gen: SEED must be nonzero");
  end
  if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
    $fatal(1, "lfsr_gen: TAPS[WIDTH-1] must be set");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             zerr_q, zerr_d;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] cnt_inc;

  assign step_val = (q_q >> 1) ^ (q_q[0] ? TAPS : '0);
  assign cnt_inc  = cnt_q + 1'b1;

`ifdef LFSR_PERIOD_EN
  logic [WIDTH-1:0] period_q, period_d;
  logic             pvalid_q, pvalid_d;
`endif

  always_comb begin
    q_d    = q_q;
    ref_d  = ref_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    zerr_d = zerr_q;
`ifdef LFSR_PERIOD_EN
    period_d = period_q;
    pvalid_d = pvalid_q;
`endif
    if (LOAD) begin
      // A zero seed would lock the register; substitute SEED and flag it.
      if (SEED_IN != '0) begin
        q_d   = SEED_IN;
        ref_d = SEED_IN;
      end else begin
        q_d    = SEED;
        ref_d  = SEED;
        zerr_d = 1'b1;
      end
      cnt_d = '0;
`ifdef LFSR_PERIOD_EN
      pvalid_d = 1'b0;
`endif
    end else if (EN) begin
      q_d = step_val;
      if (step_val == ref_q) begin
        wrap_d = 1'b1;
        cnt_d  = '0;
`ifdef LFSR_PERIOD_EN
        period_d = cnt_inc;
        pvalid_d = 1'b1;
`endif
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_q    <= SEED;
      ref_q  <= SEED;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      zerr_q <= 1'b0;
`ifdef LFSR_PERIOD_EN
      period_q <= '0;
      pvalid_q <= 1'b0;
`endif
    end else begin
      q_q    <= q_d;
      ref_q  <= ref_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      zerr_q <= zerr_d;
`ifdef LFSR_PERIOD_EN
      period_q <= period_d;
      pvalid_q <= pvalid_d;
`endif
    end
  end

  assign Q        = q_q;
  assign WRAP     = wrap_q;
  assign ZERO_ERR = zerr_q;
`ifdef LFSR_PERIOD_EN
  assign PERIOD       = period_q;
  assign PERIOD_VALID = pvalid_q;
`endif

endmodule
